recovery_sequencer: RTL and testbench

RECOVERY_SEQUENCER -- requirements
Module: recovery_sequencer

---
 rtl/recovery_sequencer.sv | 175 +++++++++++++++++
 tb/tb_recovery_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/recovery_sequencer.sv
// recovery_sequencer
// Copies the voted core register file into a recovery register file (SAVE) and
// copies it back after a collapse (RESTORE). Register x0 is never copied. A
// checkpoint can be requested explicitly or by an IDLE-cycle timer.
//
// Ports:
//   clk, rst_in               clock, synchronous active-high reset
//   ckpt_en                   enables the automatic checkpoint timer
//   ckpt_req                  checkpoint request (IDLE only)
//   rest_req                  restore request (IDLE; aborts a SAVE)
//   core_A1 / core_RD1        read port of the core register file
//   core_WE3/_A3/_WD3         write port of the core register file
//   rec_A1 / rec_RD1          read port of the recovery register file
//   rec_WE3/_A3/_WD3          write port of the recovery register file
//   stall_core, busy          high while copying
//   done                      one-cycle pulse when a save/restore completes
//   ckpt_valid                a complete checkpoint is held
//   err                       one-cycle pulse on a refused or aborted operation
module recovery_sequencer #(
  parameter int unsigned CKPT_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        ckpt_en,
  input  logic        ckpt_req,
  input  logic        rest_req,
  output logic [4:0]  core_A1,
  input  logic [31:0] core_RD1,
  output logic        core_WE3,
  output logic [4:0]  core_A3,
  output logic [31:0] core_WD3,
  output logic [4:0]  rec_A1,
  input  logic [31:0] rec_RD1,
  output logic        rec_WE3,
  output logic [4:0]  rec_A3,
  output logic [31:0] rec_WD3,
  output logic        stall_core,
  output logic        busy,
  output logic        done,
  output logic        ckpt_valid,
  output logic        err
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAVE    = 2'd1;
  localparam logic [1:0] S_RESTORE = 2'd2;

  localparam logic [AW-1:0] ADDR_FIRST = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(31);
  localparam logic [TW-1:0] TMR_LAST   = TW'(CKPT_PERIOD - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ckpt_valid_q, ckpt_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tmr_q        <= '0;
      ckpt_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tmr_q        <= tmr_d;
      ckpt_valid_q <= ckpt_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tmr_d        = tmr_q;
    ckpt_valid_d = ckpt_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rest_req) begin
          if (ckpt_valid_q) begin
            state_d = S_RESTORE;
            addr_d  = ADDR_FIRST;
            tmr_d   = '0;
          end else begin
            // Refused restore: stay idle, timer keeps running
            err_d = 1'b1;
            if (ckpt_en) tmr_d = tmr_q + TW'(1);
          end
        end else if (ckpt_req || (ckpt_en && (tmr_q == TMR_LAST))) begin
          state_d      = S_SAVE;
          addr_d       = ADDR_FIRST;
          tmr_d        = '0;
          ckpt_valid_d = 1'b0;
        end else if (ckpt_en) begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SAVE: begin
        if (rest_req) begin
          // Collapse during save: the partial checkpoint is unusable
          state_d = S_IDLE;
          addr_d  = '0;
          err_d   = 1'b1;
        end else if (addr_q == ADDR_LAST) begin
          state_d      = S_IDLE;
          addr_d       = '0;
          done_d       = 1'b1;
          ckpt_valid_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_RESTORE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Copy datapath: zero-latency read-to-write; a reset edge suppresses the write
  always_comb begin
    core_A1  = '0;
    core_WE3 = 1'b0;
    core_A3  = '0;
    core_WD3 = '0;
    rec_A1   = '0;
    rec_WE3  = 1'b0;
    rec_A3   = '0;
    rec_WD3  = '0;
    case (state_q)
      S_SAVE: begin
        core_A1 = addr_q;
        rec_A3  = addr_q;
        rec_WD3 = DW'(core_RD1);
        rec_WE3 = !rest_req && !rst_in;
      end
      S_RESTORE: begin
        rec_A1   = addr_q;
        core_A3  = addr_q;
        core_WD3 = DW'(rec_RD1);
        core_WE3 = !rst_in;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q == S_SAVE) || (state_q == S_RESTORE);
  assign stall_core = busy;
  assign done       = done_q;
  assign err        = err_q;
  assign ckpt_valid = ckpt_valid_q;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Bench for recovery_sequencer: register files modelled as arrays, expected
// behaviour from a cycle-level reference of the copy rules.
module tb_recovery_sequencer;

  localparam int unsigned P = 8;

  logic        clk = 1'b0;
  logic        rst_in, ckpt_en, ckpt_req, rest_req;
  logic [4:0]  core_A1, core_A3, rec_A1, rec_A3;
  logic [31:0] core_RD1, core_WD3, rec_RD1, rec_WD3;
  logic        core_WE3, rec_WE3, stall_core, busy, done, ckpt_valid, err;

  recovery_sequencer #(.CKPT_PERIOD(P)) dut (
    .clk(clk), .rst_in(rst_in), .ckpt_en(ckpt_en), .ckpt_req(ckpt_req),
    .rest_req(rest_req),
    .core_A1(core_A1), .core_RD1(core_RD1), .core_WE3(core_WE3),
    .core_A3(core_A3), .core_WD3(core_WD3),
    .rec_A1(rec_A1), .rec_RD1(rec_RD1), .rec_WE3(rec_WE3),
    .rec_A3(rec_A3), .rec_WD3(rec_WD3),
    .stall_core(stall_core), .busy(busy), .done(done),
    .ckpt_valid(ckpt_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Bench-side register files; load_cmd 1 = preload pattern, 2 = corrupt
  logic [31:0] core_rf [32];
  logic [31:0] rec_rf  [32];
  logic [1:0]  load_cmd;

  assign core_RD1 = core_rf[core_A1];
  assign rec_RD1  = rec_rf[rec_A1];

  always @(posedge clk) begin
    if (core_WE3) core_rf[core_A3] <= core_WD3;
    if (rec_WE3)  rec_rf[rec_A3]   <= rec_WD3;
    if (load_cmd == 2'd1) for (int i = 0; i < 32; i++) core_rf[i] <= 32'hA000_0000 + 32'(i);
    if (load_cmd == 2'd2) for (int i = 0; i < 32; i++) core_rf[i] <= 32'hDEAD_BEEF;
  end

  // Reference model: mode 0 idle, 1 saving, 2 restoring; idx = register being copied
  int          m_mode;
  int          m_idx;
  int          m_tmr;
  bit          m_valid, m_done, m_err;
  logic [31:0] core_exp [32];
  logic [31:0] rec_exp  [32];

  int n_cmp = 0;
  int n_bad = 0;
  bit last_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic ck, input logic rs, input logic en, input logic rst,
                      input bit do_chk, input logic [1:0] ld);
    logic [4:0]  e_ca1, e_ca3, e_ra1, e_ra3;
    logic [31:0] e_cwd, e_rwd;
    logic        e_cwe, e_rwe;
    @(negedge clk);
    ckpt_req = ck; rest_req = rs; ckpt_en = en; rst_in = rst; load_cmd = ld;
    #1;
    e_ca1 = '0; e_ca3 = '0; e_ra1 = '0; e_ra3 = '0; e_cwd = '0; e_rwd = '0;
    e_cwe = 1'b0; e_rwe = 1'b0;
    if (m_mode == 1) begin
      e_ca1 = 5'(m_idx); e_ra3 = 5'(m_idx); e_rwd = core_exp[m_idx]; e_rwe = !rs && !rst;
    end else if (m_mode == 2) begin
      e_ra1 = 5'(m_idx); e_ca3 = 5'(m_idx); e_cwd = rec_exp[m_idx]; e_cwe = !rst;
    end
    if (do_chk) begin
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("stall_core", 32'(stall_core), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("ckpt_valid", 32'(ckpt_valid), 32'(m_valid));
      check("core_WE3", 32'(core_WE3), 32'(e_cwe));
      check("rec_WE3", 32'(rec_WE3), 32'(e_rwe));
      check("core_A1", 32'(core_A1), 32'(e_ca1));
      check("core_A3", 32'(core_A3), 32'(e_ca3));
      check("rec_A1", 32'(rec_A1), 32'(e_ra1));
      check("rec_A3", 32'(rec_A3), 32'(e_ra3));
      check("core_WD3", core_WD3, e_cwd);
      check("rec_WD3", rec_WD3, e_rwd);
    end
    last_busy = busy;
    // Effects of the coming clock edge
    if (e_cwe) core_exp[m_idx] = e_cwd;
    if (e_rwe) rec_exp[m_idx]  = e_rwd;
    if (ld == 2'd1) for (int i = 0; i < 32; i++) core_exp[i] = 32'hA000_0000 + 32'(i);
    if (ld == 2'd2) for (int i = 0; i < 32; i++) core_exp[i] = 32'hDEAD_BEEF;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_tmr = 0; m_valid = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (m_mode == 0) begin
        if (rs) begin
          if (m_valid) begin m_mode = 2; m_idx = 1; m_tmr = 0; end
          else begin m_err = 1; if (en) m_tmr = (m_tmr + 1) % 65536; end
        end else if (ck || (en && m_tmr == int'(P) - 1)) begin
          m_mode = 1; m_idx = 1; m_tmr = 0; m_valid = 0;
        end else if (en) begin
          m_tmr = (m_tmr + 1) % 65536;
        end
      end else if (m_mode == 1 && rs) begin
        m_mode = 0; m_idx = 0; m_err = 1;
      end else if (m_idx == 31) begin
        if (m_mode == 1) m_valid = 1;
        m_mode = 0; m_idx = 0; m_done = 1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("core_rf[%0d]", i), core_rf[i], core_exp[i]);
      check($sformatf("rec_rf[%0d]", i), rec_rf[i], rec_exp[i]);
    end
  endtask

  // Runs until the current operation ends; returns the number of busy cycles
  task automatic run_busy(output int cnt);
    int guard;
    cnt = 0; guard = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      if (last_busy) cnt++;
      guard++;
    end while (last_busy && guard < 40);
    if (guard >= 40) check("busy_timeout", 32'(guard), 32'd0);
  endtask

  task automatic count_idle(output int cnt);
    cnt = 0;
    do begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
      if (!last_busy) cnt++;
    end while (!last_busy && cnt < 30);
  endtask

  initial begin
    int cnt, g;
    for (int i = 0; i < 32; i++) begin
      core_rf[i] = '0; rec_rf[i] = '0; core_exp[i] = '0; rec_exp[i] = '0;
    end
    m_mode = 0; m_idx = 0; m_tmr = 0; m_valid = 0; m_done = 0; m_err = 0;
    ckpt_req = 0; rest_req = 0; ckpt_en = 0; rst_in = 1; load_cmd = 0;

    // Reset, then a restore with no checkpoint is refused
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(3);

    // Checkpoint of the preloaded pattern
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    run_busy(cnt);
    check("save_len", 32'(cnt), 32'd31);
    check("valid_after_save", 32'(ckpt_valid), 32'd1);
    check("rec_rf[31]", rec_rf[31], 32'hA000_001F);
    check_rf();

    // Corrupt and restore
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    run_busy(cnt);
    check("restore_len", 32'(cnt), 32'd31);
    check("core_rf[17]", core_rf[17], 32'hA000_0011);
    check_rf();

    // Collapse during save at addr 10
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    g = 0;
    while (m_idx != 10 && g < 40) begin step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0); g++; end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(2);
    check("rec_rf[10]_kept", rec_rf[10], 32'hA000_000A);
    check("rec_rf[9]_new", rec_rf[9], 32'hDEAD_BEEF);
    check_rf();

    // Fresh checkpoint, then simultaneous requests pick restore; reset at addr 5
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    run_busy(cnt);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    g = 0;
    while (m_idx != 5 && g < 40) begin step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0); g++; end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    idle(2);
    check("core_rf[4]_restored", core_rf[4], 32'hA000_0004);
    check("core_rf[5]_untouched", core_rf[5], 32'hDEAD_BEEF);
    check_rf();

    // Automatic timer period
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    count_idle(cnt);
    check("tmr_first", 32'(cnt), 32'(P));
    g = 0;
    while (last_busy && g < 40) begin step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0); g++; end
    cnt = 1;
    while (!last_busy && cnt < 30) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
      if (!last_busy) cnt++;
    end
    check("tmr_after_done", 32'(cnt), 32'(P));

    // Randomized traffic
    ckpt_en = 0;
    for (int i = 0; i < 1500; i++) begin
      logic r_rst, r_ck, r_rs, r_en;
      logic [1:0] r_ld;
      r_rst = ($urandom_range(0, 149) == 0);
      r_ck  = ($urandom_range(0, 24) == 0);
      r_rs  = ($urandom_range(0, 39) == 0);
      r_en  = ($urandom_range(0, 49) == 0) ? !ckpt_en : ckpt_en;
      r_ld  = (m_mode == 0 && $urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      step(r_ck, r_rs, r_en, r_rst, 1'b1, r_ld);
    end
    idle(40);
    check_rf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
